// File: rtl/spidergon_switch_allocator.sv
// rtl/spidergon_switch_allocator.sv - separable input-first switch allocator for a Spidergon router node
// Wormhole output locking, credit flow control and zero-latency grants to the crossbar.
module spidergon_switch_allocator #(
  parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
  parameter int CREDIT_DEPTH            = 2,
  parameter int NUM_OF_PORTS            = 4,
  localparam int V  = NUM_OF_VIRTUAL_CHANNELS,
  localparam int P  = NUM_OF_PORTS,
  localparam int R  = P * V,
  localparam int CW = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [R-1:0]    i_req,
  input  logic [2*R-1:0]  i_req_out_port,
  input  logic [R-1:0]    i_req_head,
  input  logic [R-1:0]    i_req_tail,
  input  logic [P-1:0]    i_credit_return,
  output logic [R-1:0]    o_grant,
  output logic [2*P-1:0]  o_xbar_sel,
  output logic [P-1:0]    o_xbar_valid,
  output logic [P-1:0]    o_out_locked,
  output logic [CW*P-1:0] o_credit_cnt,
  output logic            o_credit_overflow
);

  localparam int PW = 2;
  localparam int VW = (V > 1) ? $clog2(V) : 1;
  localparam int RW = (R > 1) ? $clog2(R) : 1;

  logic [CW-1:0] r_credits [P];
  logic [P-1:0]  r_lock;
  logic [RW-1:0] r_owner   [P];
  logic [VW-1:0] r_ptr_in  [P];
  logic [PW-1:0] r_ptr_out [P];
  logic          r_overflow;

  logic [PW-1:0] w_port     [R];
  logic [R-1:0]  w_elig;
  logic [P-1:0]  w_s1_valid;
  logic [VW-1:0] w_s1_vc    [P];
  logic [PW-1:0] w_s1_port  [P];
  logic [P-1:0]  w_s2_valid;
  logic [PW-1:0] w_s2_sel   [P];
  logic [RW-1:0] w_win      [P];

  // A locked output only admits its owner; an unlocked one only admits a head flit.
  always_comb begin
    for (int r = 0; r < R; r++) begin
      w_port[r] = i_req_out_port[2*r +: 2];
      w_elig[r] = i_req[r] && (r_credits[w_port[r]] != '0) &&
                  (r_lock[w_port[r]] ? (r_owner[w_port[r]] == RW'(r)) : i_req_head[r]);
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int p = 0; p < P; p++) begin
      w_s1_valid[p] = 1'b0;
      w_s1_vc[p]    = '0;
      w_s1_port[p]  = '0;
      for (int k = 0; k < V; k++) begin
        idx = p * V + (int'(r_ptr_in[p]) + k) % V;
        if (!w_s1_valid[p] && w_elig[RW'(idx)]) begin
          w_s1_valid[p] = 1'b1;
          w_s1_vc[p]    = VW'((int'(r_ptr_in[p]) + k) % V);
          w_s1_port[p]  = w_port[RW'(idx)];
        end
      end
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < P; o++) begin
      w_s2_valid[o] = 1'b0;
      w_s2_sel[o]   = '0;
      w_win[o]      = '0;
      for (int k = 0; k < P; k++) begin
        idx = (int'(r_ptr_out[o]) + k) % P;
        if (!w_s2_valid[o] && w_s1_valid[PW'(idx)] && (w_s1_port[PW'(idx)] == PW'(o))) begin
          w_s2_valid[o] = 1'b1;
          w_s2_sel[o]   = PW'(idx);
          w_win[o]      = RW'(idx * V + int'(w_s1_vc[PW'(idx)]));
        end
      end
    end
  end

  // Outputs are gated by reset so they drop the moment reset asserts.
  always_comb begin
    o_grant      = '0;
    o_xbar_valid = '0;
    o_xbar_sel   = '0;
    o_credit_cnt = '0;
    for (int o = 0; o < P; o++) begin
      o_credit_cnt[CW*o +: CW] = r_credits[o];
      if (i_reset && w_s2_valid[o]) begin
        o_grant[w_win[o]]     = 1'b1;
        o_xbar_valid[o]       = 1'b1;
        o_xbar_sel[2*o +: 2]  = w_s2_sel[o];
      end
    end
  end

  assign o_out_locked      = r_lock;
  assign o_credit_overflow = r_overflow;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_lock     <= '0;
      r_overflow <= 1'b0;
      for (int o = 0; o < P; o++) begin
        r_credits[o] <= CW'(CREDIT_DEPTH);
        r_owner[o]   <= '0;
        r_ptr_out[o] <= '0;
        r_ptr_in[o]  <= '0;
      end
    end else begin
      for (int o = 0; o < P; o++) begin
        if (w_s2_valid[o] && !i_credit_return[o]) begin
          r_credits[o] <= r_credits[o] - CW'(1);
        end else if (!w_s2_valid[o] && i_credit_return[o]) begin
          if (r_credits[o] == CW'(CREDIT_DEPTH)) r_overflow <= 1'b1;
          else                                   r_credits[o] <= r_credits[o] + CW'(1);
        end
        if (w_s2_valid[o]) begin
          r_ptr_out[o]           <= PW'((int'(w_s2_sel[o]) + 1) % P);
          r_ptr_in[w_s2_sel[o]]  <= VW'((int'(w_s1_vc[w_s2_sel[o]]) + 1) % V);
          if (i_req_head[w_win[o]] && !i_req_tail[w_win[o]]) begin
            r_lock[o]  <= 1'b1;
            r_owner[o] <= w_win[o];
          end else if (i_req_tail[w_win[o]] && !i_req_head[w_win[o]]) begin
            r_lock[o]  <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spidergon_switch_allocator.sv
// tb/tb_spidergon_switch_allocator.sv - scoreboard bench for spidergon_switch_allocator
// Stimulus pushes per-cycle expectations; a monitor pops and compares at the falling edge.
module tb_spidergon_switch_allocator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req, head, tail, grant;
  logic [15:0] out_port;
  logic [3:0]  ret, xv, locked;
  logic [7:0]  sel, cred;
  logic        ovf;

  typedef struct packed {
    logic [7:0] grant;
    logic [3:0] xv;
    logic [7:0] sel;
    logic [7:0] cred;
    logic [3:0] lock;
    logic       ovf;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;
  event  mon_ev;

  spidergon_switch_allocator dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_req            (req),
    .i_req_out_port   (out_port),
    .i_req_head       (head),
    .i_req_tail       (tail),
    .i_credit_return  (ret),
    .o_grant          (grant),
    .o_xbar_sel       (sel),
    .o_xbar_valid     (xv),
    .o_out_locked     (locked),
    .o_credit_cnt     (cred),
    .o_credit_overflow(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pv(input int r, input int o);
    logic [15:0] t;
    t = '0;
    t[2*r +: 2] = 2'(o);
    return t;
  endfunction

  function automatic logic [7:0] sv(input int o, input int p);
    logic [7:0] t;
    t = '0;
    t[2*o +: 2] = 2'(p);
    return t;
  endfunction

  task automatic push(input string nm, input logic [7:0] eg, input logic [3:0] exv,
                      input logic [7:0] esel, input logic [7:0] ecr,
                      input logic [3:0] elk, input logic eovf);
    exp_t e;
    e.grant = eg; e.xv = exv; e.sel = esel; e.cred = ecr; e.lock = elk; e.ovf = eovf;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic cyc(input string nm, input logic [7:0] rq, input logic [15:0] pt,
                     input logic [7:0] hd, input logic [7:0] tl, input logic [3:0] rt,
                     input logic [7:0] eg, input logic [3:0] exv, input logic [7:0] esel,
                     input logic [7:0] ecr, input logic [3:0] elk, input logic eovf);
    @(posedge clk);
    #1;
    req = rq; out_port = pt; head = hd; tail = tl; ret = rt;
    push(nm, eg, exv, esel, ecr, elk, eovf);
  endtask

  task automatic compare();
    exp_t       e;
    string      nm;
    logic [7:0] mask;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    for (int o = 0; o < 4; o++) mask[2*o +: 2] = {2{e.xv[o]}};
    checks++;
    if (grant !== e.grant || xv !== e.xv || (sel & mask) !== e.sel ||
        cred !== e.cred || locked !== e.lock || ovf !== e.ovf) begin
      errors++;
      $display("FAIL %s: got grant=%h xv=%b sel=%h cred=%h lock=%b ovf=%b, required grant=%h xv=%b sel=%h cred=%h lock=%b ovf=%b",
               nm, grant, xv, sel & mask, cred, locked, ovf,
               e.grant, e.xv, e.sel, e.cred, e.lock, e.ovf);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or mon_ev);
      if (exp_q.size() != 0) compare();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = '0; out_port = '0; head = '0; tail = '0; ret = '0;
    #12 rst_n = 1'b1;

    cyc("t1_reset_state", 0, 0, 0, 0, 0, 8'h00, 4'b0000, 8'h00, 8'hAA, 4'b0000, 0);

    cyc("t2_same_cycle",  8'h04, pv(2,3), 8'h04, 8'h04, 4'b0000, 8'h04, 4'b1000, sv(3,1), 8'hAA, 0, 0);
    cyc("t2_credit_dec",  0, 0, 0, 0, 4'b1000, 0, 0, 0, 8'h6A, 0, 0);
    cyc("t2_restored",    0, 0, 0, 0, 4'b0000, 0, 0, 0, 8'hAA, 0, 0);

    cyc("t3_rr_c1", 8'h11, pv(0,1)|pv(4,1), 8'h11, 8'h11, 4'b0000, 8'h01, 4'b0010, sv(1,0), 8'hAA, 0, 0);
    cyc("t3_rr_c2", 8'h11, pv(0,1)|pv(4,1), 8'h11, 8'h11, 4'b0010, 8'h10, 4'b0010, sv(1,2), 8'hA6, 0, 0);
    cyc("t3_rr_c3", 8'h11, pv(0,1)|pv(4,1), 8'h11, 8'h11, 4'b0010, 8'h01, 4'b0010, sv(1,0), 8'hA6, 0, 0);
    cyc("t3_rr_c4", 8'h11, pv(0,1)|pv(4,1), 8'h11, 8'h11, 4'b0010, 8'h10, 4'b0010, sv(1,2), 8'hA6, 0, 0);
    cyc("t3_rr_end", 0, 0, 0, 0, 4'b0010, 0, 0, 0, 8'hA6, 0, 0);

    cyc("t3_vc_c1", 8'h0C, pv(2,0)|pv(3,3), 8'h0C, 8'h0C, 4'b0000, 8'h08, 4'b1000, sv(3,1), 8'hAA, 0, 0);
    cyc("t3_vc_c2", 8'h0C, pv(2,0)|pv(3,3), 8'h0C, 8'h0C, 4'b0000, 8'h04, 4'b0001, sv(0,1), 8'h6A, 0, 0);
    cyc("t3_vc_c3", 8'h0C, pv(2,0)|pv(3,3), 8'h0C, 8'h0C, 4'b0000, 8'h08, 4'b1000, sv(3,1), 8'h69, 0, 0);
    cyc("t3_vc_c4", 8'h0C, pv(2,0)|pv(3,3), 8'h0C, 8'h0C, 4'b0000, 8'h04, 4'b0001, sv(0,1), 8'h29, 0, 0);
    cyc("t3_vc_ret1", 0, 0, 0, 0, 4'b1001, 0, 0, 0, 8'h28, 0, 0);
    cyc("t3_vc_ret2", 0, 0, 0, 0, 4'b1001, 0, 0, 0, 8'h69, 0, 0);

    cyc("t4_head",      8'h02, pv(1,2)|pv(6,2), 8'h02, 8'h00, 4'b0000, 8'h02, 4'b0100, sv(2,0), 8'hAA, 4'b0000, 0);
    cyc("t4_body_blk",  8'h42, pv(1,2)|pv(6,2), 8'h40, 8'h00, 4'b0100, 8'h02, 4'b0100, sv(2,0), 8'h9A, 4'b0100, 0);
    cyc("t4_tail_blk",  8'h42, pv(1,2)|pv(6,2), 8'h40, 8'h02, 4'b0100, 8'h02, 4'b0100, sv(2,0), 8'h9A, 4'b0100, 0);
    cyc("t4_next_head", 8'h40, pv(1,2)|pv(6,2), 8'h40, 8'h00, 4'b0100, 8'h40, 4'b0100, sv(2,3), 8'h9A, 4'b0000, 0);
    cyc("t4_r6_body1",  8'h40, pv(1,2)|pv(6,2), 8'h00, 8'h00, 4'b0100, 8'h40, 4'b0100, sv(2,3), 8'h9A, 4'b0100, 0);
    cyc("t6_pre_reset", 8'h40, pv(1,2)|pv(6,2), 8'h00, 8'h00, 4'b0000, 8'h40, 4'b0100, sv(2,3), 8'h9A, 4'b0100, 0);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    push("t6_async_drop", 8'h00, 4'b0000, 8'h00, 8'hAA, 4'b0000, 0);
    -> mon_ev;
    #1;
    req = '0; out_port = '0; head = '0; tail = '0; ret = '0;
    rst_n = 1'b1;
    cyc("t6_after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 8'hAA, 4'b0000, 0);

    cyc("t5_g1",      8'h01, 16'h0, 8'h01, 8'h01, 4'b0000, 8'h01, 4'b0001, sv(0,0), 8'hAA, 0, 0);
    cyc("t5_g2",      8'h01, 16'h0, 8'h01, 8'h01, 4'b0000, 8'h01, 4'b0001, sv(0,0), 8'hA9, 0, 0);
    cyc("t5_stall",   8'h01, 16'h0, 8'h01, 8'h01, 4'b0000, 8'h00, 4'b0000, 8'h00,   8'hA8, 0, 0);
    cyc("t5_ret_n",   8'h01, 16'h0, 8'h01, 8'h01, 4'b0001, 8'h00, 4'b0000, 8'h00,   8'hA8, 0, 0);
    cyc("t5_grant_n1",8'h01, 16'h0, 8'h01, 8'h01, 4'b0000, 8'h01, 4'b0001, sv(0,0), 8'hA9, 0, 0);
    cyc("t5_ret_a",   0, 0, 0, 0, 4'b0001, 0, 0, 0, 8'hA8, 0, 0);
    cyc("t5_ret_b",   0, 0, 0, 0, 4'b0001, 0, 0, 0, 8'hA9, 0, 0);
    cyc("t5_ret_full",0, 0, 0, 0, 4'b0001, 0, 0, 0, 8'hAA, 0, 0);
    cyc("t5_overflow",0, 0, 0, 0, 4'b0000, 0, 0, 0, 8'hAA, 0, 1);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
